// File: rtl/al4s3b_wb_pkg.sv
// Shared Wishbone definitions used by the initiator and the register-responder blocks:
// state encoding, timeout defaults and the read value returned on an aborted cycle.
package al4s3b_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CYCLE = 2'd1,
        ST_RESP  = 2'd2
    } wb_state_e;

    localparam int unsigned WB_CNTR_WIDTH         = 3;
    localparam int unsigned WB_CNTR_TIMEOUT       = 7;
    localparam logic [31:0] WB_DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/al4s3b_wb_timeout_cntr.sv
// Wait-cycle counter for a Wishbone cycle: cleared at command accept, counts while
// the responder withholds ACK, flags the terminal count.
module al4s3b_wb_timeout_cntr #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/al4s3b_wb.sv
// Single-outstanding Wishbone initiator: one command in, one bus cycle out, one
// response held until consumed; cycles without ACK abort after a bounded wait.
module al4s3b_wb_initiator
    import al4s3b_wb_pkg::*;
#(
    parameter int                  ADDRWIDTH            = 17,
    parameter int                  DATAWIDTH            = 32,
    parameter int                  DEFAULT_CNTR_WIDTH   = WB_CNTR_WIDTH,
    parameter int                  DEFAULT_CNTR_TIMEOUT = WB_CNTR_TIMEOUT,
    parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE  = WB_DEFAULT_READ_VALUE
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST_N,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [ADDRWIDTH-1:0] cmd_adr,
    input  logic [3:0]           cmd_byte_stb,
    input  logic [DATAWIDTH-1:0] cmd_wr_dat,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_rd_dat,
    output logic                 rsp_err,
    output logic [ADDRWIDTH-1:0] WBs_ADR,
    output logic                 WBs_CYC,
    output logic                 WBs_STB,
    output logic                 WBs_WE,
    output logic                 WBs_RD,
    output logic [3:0]           WBs_BYTE_STB,
    output logic [DATAWIDTH-1:0] WBs_WR_DAT,
    input  logic [DATAWIDTH-1:0] WBs_RD_DAT,
    input  logic                 WBs_ACK,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    wb_state_e            state_q, state_d;
    logic                 we_q;
    logic [ADDRWIDTH-1:0] adr_q;
    logic [3:0]           byte_stb_q;
    logic [DATAWIDTH-1:0] wr_dat_q;
    logic [DATAWIDTH-1:0] rsp_rd_dat_q, rsp_rd_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 latch_en;
    logic                 cntr_clr, cntr_en, cntr_tc;
    logic                 in_cycle;

    al4s3b_wb_timeout_cntr #(
        .WIDTH    (DEFAULT_CNTR_WIDTH),
        .TERMINAL (DEFAULT_CNTR_TIMEOUT)
    ) u_timeout_cntr (
        .clk_i  (WB_CLK),
        .rst_ni (WB_RST_N),
        .clr_i  (cntr_clr),
        .en_i   (cntr_en),
        .tc_o   (cntr_tc)
    );

    always_comb begin
        state_d      = state_q;
        rsp_rd_dat_d = rsp_rd_dat_q;
        rsp_err_d    = rsp_err_q;
        err_cnt_d    = err_cnt_q;
        latch_en     = 1'b0;
        cntr_clr     = 1'b0;
        cntr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    latch_en = 1'b1;
                    cntr_clr = 1'b1;
                    state_d  = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                // ACK on the terminal count still completes normally
                if (WBs_ACK) begin
                    rsp_rd_dat_d = we_q ? '0 : WBs_RD_DAT;
                    rsp_err_d    = 1'b0;
                    state_d      = ST_RESP;
                end else if (cntr_tc) begin
                    rsp_rd_dat_d = DEFAULT_READ_VALUE;
                    rsp_err_d    = 1'b1;
                    err_cnt_d    = sat_inc8(err_cnt_q);
                    state_d      = ST_RESP;
                end else begin
                    cntr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            state_q      <= ST_IDLE;
            rsp_rd_dat_q <= '0;
            rsp_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rsp_rd_dat_q <= rsp_rd_dat_d;
            rsp_err_q    <= rsp_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Command fields only reach the bus through in_cycle gating, so they need no reset
    always_ff @(posedge WB_CLK) begin
        if (latch_en) begin
            we_q       <= cmd_we;
            adr_q      <= cmd_adr;
            byte_stb_q <= cmd_byte_stb;
            wr_dat_q   <= cmd_wr_dat;
        end
    end

    assign in_cycle     = (state_q == ST_CYCLE);
    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rd_dat   = rsp_rd_dat_q;
    assign rsp_err      = rsp_err_q;
    assign err_cnt      = err_cnt_q;
    assign WBs_CYC      = in_cycle;
    assign WBs_STB      = in_cycle;
    assign WBs_WE       = in_cycle & we_q;
    assign WBs_RD       = in_cycle & ~we_q;
    assign WBs_ADR      = in_cycle ? adr_q      : '0;
    assign WBs_BYTE_STB = in_cycle ? byte_stb_q : '0;
    assign WBs_WR_DAT   = in_cycle ? wr_dat_q   : '0;

endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
// Bench for al4s3b_wb_initiator: a scripted Wishbone responder plus a transaction-level
// model of the expected response, bus occupancy and timeout count.
module tb_al4s3b_wb_initiator;

    localparam int TIMEOUT = 7;
    localparam logic [31:0] BAD_VALUE = 32'hBADFABAC;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [16:0] cmd_adr;
    logic [3:0]  cmd_byte_stb;
    logic [31:0] cmd_wr_dat;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rd_dat;
    logic [16:0] WBs_ADR;
    logic        WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_ACK;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT, WBs_RD_DAT;
    logic        busy;
    logic [7:0]  err_cnt;

    int tests;
    int fails;
    int model_err_cnt;

    // Responder scenario, set by the tasks and consumed by the responder process
    logic        exp_we;
    logic [16:0] exp_adr;
    logic [3:0]  exp_bs;
    logic [31:0] exp_wd;
    logic [31:0] rd_src;
    int          ack_target;
    logic        stray_ack;
    int          txn_seq;
    int          seen_seq;
    int          stb_cnt;
    int          bus_bad;

    al4s3b_wb_initiator dut (
        .WB_CLK       (clk),
        .WB_RST_N     (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_we       (cmd_we),
        .cmd_adr      (cmd_adr),
        .cmd_byte_stb (cmd_byte_stb),
        .cmd_wr_dat   (cmd_wr_dat),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd_dat   (rsp_rd_dat),
        .rsp_err      (rsp_err),
        .WBs_ADR      (WBs_ADR),
        .WBs_CYC      (WBs_CYC),
        .WBs_STB      (WBs_STB),
        .WBs_WE       (WBs_WE),
        .WBs_RD       (WBs_RD),
        .WBs_BYTE_STB (WBs_BYTE_STB),
        .WBs_WR_DAT   (WBs_WR_DAT),
        .WBs_RD_DAT   (WBs_RD_DAT),
        .WBs_ACK      (WBs_ACK),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: counts STB cycles of the current transaction, raises ACK on the
    // scripted one, and checks the bus fields every cycle.
    always @(posedge clk) begin
        #1;
        if (seen_seq != txn_seq) begin
            seen_seq = txn_seq;
            stb_cnt  = 0;
        end
        if (WBs_STB === 1'b1) begin
            stb_cnt = stb_cnt + 1;
            if (WBs_CYC !== 1'b1 || WBs_WE !== exp_we || WBs_RD !== ~exp_we ||
                WBs_ADR !== exp_adr || WBs_BYTE_STB !== exp_bs || WBs_WR_DAT !== exp_wd)
                bus_bad = bus_bad + 1;
            WBs_ACK    = (stb_cnt == ack_target);
            WBs_RD_DAT = WBs_ACK ? rd_src : $urandom;
        end else begin
            if (WBs_CYC !== 1'b0 || WBs_WE !== 1'b0 || WBs_RD !== 1'b0 ||
                WBs_ADR !== 17'd0 || WBs_BYTE_STB !== 4'd0 || WBs_WR_DAT !== 32'd0)
                bus_bad = bus_bad + 1;
            WBs_ACK    = stray_ack;
            WBs_RD_DAT = $urandom;
        end
    end

    task automatic do_txn(input string name, input logic we, input logic [16:0] adr,
                          input logic [3:0] bs, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_at, input int wait_n, input logic stray);
        logic        e_err;
        logic [31:0] e_dat;
        int          e_stb;
        int          bad0;
        int          cyc;
        if (ack_at >= 1 && ack_at <= TIMEOUT + 1) begin
            e_err = 1'b0;
            e_dat = we ? 32'd0 : rd;
            e_stb = ack_at;
        end else begin
            e_err = 1'b1;
            e_dat = BAD_VALUE;
            e_stb = TIMEOUT + 1;
            if (model_err_cnt < 255) model_err_cnt = model_err_cnt + 1;
        end
        @(negedge clk);
        exp_we = we; exp_adr = adr; exp_bs = bs; exp_wd = wd; rd_src = rd;
        ack_target = ack_at; stray_ack = 1'b0; txn_seq = txn_seq + 1; bad0 = bus_bad;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_byte_stb = bs; cmd_wr_dat = wd;
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s cmd_ready before accept: got %b want 1", name, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we = 1'($urandom); cmd_adr = 17'($urandom); cmd_byte_stb = 4'($urandom); cmd_wr_dat = $urandom;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++; $display("FAIL %s rsp_valid wait: got %b want 1 within 20 cycles", name, rsp_valid);
        end
        tests++;
        if (rsp_err !== e_err || rsp_rd_dat !== e_dat) begin
            fails++; $display("FAIL %s response: got err=%b dat=%h want err=%b dat=%h", name, rsp_err, rsp_rd_dat, e_err, e_dat);
        end
        tests++;
        if (stb_cnt != e_stb) begin
            fails++; $display("FAIL %s stb cycles: got %0d want %0d", name, stb_cnt, e_stb);
        end
        tests++;
        if (err_cnt !== 8'(model_err_cnt)) begin
            fails++; $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, model_err_cnt);
        end
        stray_ack = stray;
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_err !== e_err || rsp_rd_dat !== e_dat || cmd_ready !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("FAIL %s hold cycle %0d: got valid=%b err=%b dat=%h ready=%b want 1/%b/%h/0", name, i, rsp_valid, rsp_err, rsp_rd_dat, cmd_ready, e_err, e_dat);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        stray_ack = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL %s after consume: got ready=%b busy=%b valid=%b want 1/0/0", name, cmd_ready, busy, rsp_valid);
        end
        tests++;
        if (bus_bad != bad0) begin
            fails++; $display("FAIL %s bus fields: got %0d bad cycles want 0", name, bus_bad - bad0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (WBs_CYC !== 0 || WBs_STB !== 0 || WBs_WE !== 0 || WBs_RD !== 0 || rsp_valid !== 0 ||
            rsp_rd_dat !== 32'd0 || rsp_err !== 0 || err_cnt !== 8'd0 || busy !== 0) begin
            fails++; $display("FAIL reset_state: got cyc=%b stb=%b valid=%b dat=%h err=%b cnt=%0d busy=%b want all 0", WBs_CYC, WBs_STB, rsp_valid, rsp_rd_dat, rsp_err, err_cnt, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        model_err_cnt = 0;
    endtask

    task automatic test_write_ack2();
        do_txn("write_ack2", 1'b1, 17'h00008, 4'hF, 32'h12345678, 32'hDEADBEEF, 2, 0, 1'b0);
    endtask

    task automatic test_read_immediate();
        do_txn("read_imm", 1'b0, 17'h00000, 4'hF, 32'h0, 32'hA5A50001, 1, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn("read_timeout", 1'b0, 17'h1F000, 4'hF, 32'h0, 32'h11112222, 0, 0, 1'b0);
        do_txn("write_timeout", 1'b1, 17'h1F004, 4'h3, 32'hCAFE0000, 32'h0, 0, 0, 1'b0);
    endtask

    task automatic test_ack_terminal();
        do_txn("ack_terminal", 1'b0, 17'h00010, 4'hF, 32'h0, 32'h5A5A7777, TIMEOUT + 1, 0, 1'b0);
    endtask

    task automatic test_resp_hold();
        do_txn("resp_hold", 1'b0, 17'h00020, 4'hF, 32'h0, 32'h0BADCAFE, 3, 5, 1'b1);
    endtask

    task automatic test_reset_mid_cycle();
        @(negedge clk);
        exp_we = 1'b0; exp_adr = 17'h00044; exp_bs = 4'hF; exp_wd = 32'h0; rd_src = 32'h0;
        ack_target = 0; stray_ack = 1'b0; txn_seq = txn_seq + 1;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 17'h00044; cmd_byte_stb = 4'hF; cmd_wr_dat = 32'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (WBs_STB !== 1'b1) begin
            fails++; $display("FAIL rst_mid pre-reset stb: got %b want 1", WBs_STB);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (WBs_CYC !== 1'b0 || WBs_STB !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_mid async drop: got cyc=%b stb=%b valid=%b busy=%b cnt=%0d want 0", WBs_CYC, WBs_STB, rsp_valid, busy, err_cnt);
        end
        model_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 3) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b0 || WBs_STB !== 1'b0) begin
                fails++; $display("FAIL rst_mid no response: got valid=%b stb=%b want 0", rsp_valid, WBs_STB);
            end
        end
        do_txn("rst_mid_next", 1'b0, 17'h00048, 4'hF, 32'h0, 32'h00C0FFEE, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_txn("random", 1'($urandom), 17'($urandom), 4'($urandom), $urandom, $urandom,
                   int'($urandom_range(9, 0)), int'($urandom_range(3, 0)), 1'($urandom));
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            do_txn("saturate", 1'($urandom), 17'($urandom), 4'hF, $urandom, $urandom, 0, 0, 1'b0);
        end
    endtask

    initial begin
        tests = 0; fails = 0; model_err_cnt = 0;
        cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_byte_stb = '0; cmd_wr_dat = '0;
        rsp_ready = 0; WBs_ACK = 0; WBs_RD_DAT = '0;
        exp_we = 0; exp_adr = '0; exp_bs = '0; exp_wd = '0; rd_src = '0;
        ack_target = 0; stray_ack = 0; txn_seq = 0; seen_seq = 0; stb_cnt = 0; bus_bad = 0;
        test_reset();
        test_write_ack2();
        test_read_immediate();
        test_timeout();
        test_ack_terminal();
        test_resp_hold();
        test_reset_mid_cycle();
        test_random();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
